// File: rtl/seq_multiplier.sv
// Signed 8x8 sequential multiplier: magnitude shift-and-add over 8 cycles, then sign fix.
// START accepted in IDLE/DONE_ST; Product/DONE appear 9 cycles after the accepting edge.
module seq_multiplier (
  input  logic        CLOCK,
  input  logic        RESET_N,
  input  logic        START,
  input  logic [7:0]  Multiplicand,
  input  logic [7:0]  Multiplier,
  output logic [15:0] Product,
  output logic        DONE,
  output logic        BUSY
);

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE_ST} state_t;

  state_t      state, next_state;
  logic [7:0]  m_reg, a_reg, q_reg;
  logic [3:0]  cnt;
  logic        neg;
  logic        accept;
  logic [8:0]  sum;
  logic [15:0] aq;

  function automatic logic [7:0] magnitude(input logic [7:0] x);
    return x[7] ? (~x + 8'd1) : x;
  endfunction

  always_comb begin
    next_state = state;
    accept     = 1'b0;
    case (state)
      IDLE, DONE_ST: begin
        if (START) begin
          accept     = 1'b1;
          next_state = RUN;
        end
      end
      RUN:     if (cnt == 4'd7) next_state = FIX;
      FIX:     next_state = DONE_ST;
      default: next_state = IDLE;
    endcase
  end

  // The carry bit lives only in sum[8]; after the shift it is always zero again.
  assign sum = {1'b0, a_reg} + (q_reg[0] ? {1'b0, m_reg} : 9'd0);
  assign aq  = {a_reg, q_reg};

  always_ff @(posedge CLOCK) begin
    if (!RESET_N) begin
      state   <= IDLE;
      m_reg   <= 8'd0;
      a_reg   <= 8'd0;
      q_reg   <= 8'd0;
      cnt     <= 4'd0;
      neg     <= 1'b0;
      Product <= 16'd0;
    end else begin
      state <= next_state;
      if (accept) begin
        m_reg <= magnitude(Multiplicand);
        q_reg <= magnitude(Multiplier);
        neg   <= Multiplicand[7] ^ Multiplier[7];
        a_reg <= 8'd0;
        cnt   <= 4'd0;
      end else if (state == RUN) begin
        a_reg <= sum[8:1];
        q_reg <= {sum[0], q_reg[7:1]};
        cnt   <= cnt + 4'd1;
      end else if (state == FIX) begin
        // Negating zero yields zero, so no negative-zero case exists.
        Product <= neg ? (~aq + 16'd1) : aq;
      end
    end
  end

  assign DONE = (state == DONE_ST);
  assign BUSY = (state == RUN) || (state == FIX);

endmodule

// File: tb/tb_seq_multiplier.sv
// Scoreboard bench for seq_multiplier: stimulus pushes expected product and due edge,
// a negedge monitor pops on each rising DONE and checks value and latency.
module tb_seq_multiplier;

  logic        CLOCK = 1'b0;
  logic        RESET_N = 1'b0;
  logic        START = 1'b0;
  logic [7:0]  Multiplicand = 8'd0;
  logic [7:0]  Multiplier = 8'd0;
  logic [15:0] Product;
  logic        DONE;
  logic        BUSY;

  seq_multiplier dut (
    .CLOCK(CLOCK), .RESET_N(RESET_N), .START(START),
    .Multiplicand(Multiplicand), .Multiplier(Multiplier),
    .Product(Product), .DONE(DONE), .BUSY(BUSY)
  );

  always #5 CLOCK = ~CLOCK;

  typedef struct {
    logic [15:0] prod;
    int          due;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  logic prev_done = 1'b0;

  always @(posedge CLOCK) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [15:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
    int x, y;
    x = int'($signed(a));
    y = int'($signed(b));
    return 16'(x * y);
  endfunction

  // Monitor: every fresh DONE must match the oldest outstanding request.
  always @(negedge CLOCK) begin
    if (RESET_N && DONE && !prev_done) begin
      if (q.size() == 0) begin
        chk("spurious_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("product", {16'd0, Product}, {16'd0, e.prod});
        chk("latency", cyc, e.due);
      end
    end
    prev_done = DONE;
  end

  // Drives one accepted request (accept edge = next posedge) and releases START after it.
  task automatic start_op(input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    @(posedge CLOCK); #1;
    Multiplicand = a;
    Multiplier   = b;
    START        = 1'b1;
    e.prod = ref_mul(a, b);
    e.due  = cyc + 10;
    q.push_back(e);
    @(posedge CLOCK); #1;
    START = 1'b0;
  endtask

  task automatic wait_done(input int exp_busy);
    int  busy_cnt = 0;
    bit  seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge CLOCK);
      if (BUSY) busy_cnt++;
      if (DONE) seen = 1;
    end
    chk("done_seen", 32'(seen), 32'd1);
    chk("busy_cycles", busy_cnt, exp_busy);
  endtask

  initial begin
    logic [7:0] ta, tb;
    exp_t e;

    // Reset state
    repeat (2) @(posedge CLOCK);
    #1 RESET_N = 1'b1;
    @(negedge CLOCK);
    chk("rst_product", {16'd0, Product}, 32'h0);
    chk("rst_done", 32'(DONE), 32'd0);
    chk("rst_busy", 32'(BUSY), 32'd0);

    // 7 x 6, then DONE and Product hold
    start_op(8'd7, 8'd6);
    wait_done(9);
    repeat (3) begin
      @(negedge CLOCK);
      chk("hold_done", 32'(DONE), 32'd1);
      chk("hold_product", {16'd0, Product}, 32'h002A);
    end

    // Signs and extremes
    start_op(8'hF9, 8'd6);   wait_done(9);
    start_op(8'd7, 8'hFA);   wait_done(9);
    start_op(8'hF9, 8'hFA);  wait_done(9);
    start_op(8'h80, 8'h80);  wait_done(9);
    start_op(8'h80, 8'd127); wait_done(9);
    start_op(8'd127, 8'd127); wait_done(9);
    start_op(8'd0, 8'hFB);   wait_done(9);
    start_op(8'hFF, 8'h00);  wait_done(9);

    // START during RUN is ignored: pulse at edge 4 with 9 x 9
    start_op(8'd3, 8'd4);
    repeat (3) @(posedge CLOCK);
    #1; Multiplicand = 8'd9; Multiplier = 8'd9; START = 1'b1;
    @(posedge CLOCK); #1; START = 1'b0;
    wait_done(5);
    @(negedge CLOCK);
    chk("ignored_start_product", {16'd0, Product}, 32'h000C);

    // Reset at edge 5 of 100 x 2 discards the operation
    start_op(8'd100, 8'd2);
    repeat (4) @(posedge CLOCK);
    #1; RESET_N = 1'b0;
    void'(q.pop_back());
    @(posedge CLOCK); #1; RESET_N = 1'b1;
    @(negedge CLOCK);
    chk("midrst_product", {16'd0, Product}, 32'h0);
    chk("midrst_done", 32'(DONE), 32'd0);
    chk("midrst_busy", 32'(BUSY), 32'd0);
    start_op(8'd2, 8'd3);
    wait_done(9);

    // Back-to-back with START held high
    @(posedge CLOCK); #1;
    Multiplicand = 8'd5; Multiplier = 8'd5; START = 1'b1;
    e.prod = 16'h0019; e.due = cyc + 10; q.push_back(e);
    @(posedge CLOCK); #1;
    wait_done(9);
    Multiplicand = 8'hFF; Multiplier = 8'd1;
    e.prod = 16'hFFFF; e.due = cyc + 10; q.push_back(e);
    @(posedge CLOCK); #1; START = 1'b0;
    @(negedge CLOCK);
    chk("b2b_done_one_cycle", 32'(DONE), 32'd0);
    chk("b2b_product_kept", {16'd0, Product}, 32'h0019);
    wait_done(8);

    // Randomized operands against the arithmetic reference
    for (int n = 0; n < 40; n++) begin
      ta = 8'($urandom);
      tb = 8'($urandom_range(0, 3) == 0 ? 8'h80 : $urandom);
      start_op(ta, tb);
      wait_done(9);
    end

    repeat (2) @(negedge CLOCK);
    chk("queue_drained", q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_multiplier.md
# seq_multiplier

Sequential signed 8x8 multiplier producing a 16-bit two's-complement product with a START/DONE handshake. It is the companion to the sequential divider in the Lab 5 datapath: a multiply of an 8-bit quotient by an 8-bit divisor regenerates a 16-bit dividend. Internally it converts operands to magnitude, runs 8 shift-and-add iterations, and applies the result sign.

## Interface
- No parameters; widths are fixed at 8-bit operands and a 16-bit product.
- CLOCK  in  1  rising-edge clock for all state.
- RESET_N  in  1  synchronous, active-low reset, sampled on the CLOCK rising edge.
- START  in  1  request; sampled only in IDLE or DONE_ST.
- Multiplicand  in  8  signed two's-complement operand; sampled at the accepting edge.
- Multiplier  in  8  signed two's-complement operand; sampled at the accepting edge.
- Product  out  16  signed result register; updated only on completion.
- DONE  out  1  high from completion until the next accepted START or reset.
- BUSY  out  1  high while an operation is in progress (RUN, FIX).

## Operation
- Registers:
  - M[7:0]: multiplicand magnitude.
  - A[7:0] plus carry bit C: accumulator.
  - Q[7:0]: multiplier magnitude, shifted out LSB first.
  - cnt[3:0]: iteration counter.
  - neg: result sign.
  - Product[15:0]: result.
- States:
  - IDLE: waiting for START.
  - RUN: 8 add/shift iterations.
  - FIX: sign correction and Product load.
  - DONE_ST: result presented.
- Accept (IDLE or DONE_ST, START=1):
  - M = |Multiplicand|, Q = |Multiplier|. Magnitude is ~x+1 when the MSB is 1, otherwise x. -128 gives unsigned 128 (8'h80).
  - neg = Multiplicand[7] ^ Multiplier[7]; A=0, C=0, cnt=0; DONE cleared; go to RUN.
- RUN, one iteration per cycle:
  - {C,A} = Q[0] ? A+M (9-bit) : {0,A}.
  - Then {C,A,Q} is shifted right by one, with 0 into C.
  - cnt increments. After the 8th iteration (cnt reaches 8), go to FIX.
- FIX: Product = neg ? ~{A,Q}+1 : {A,Q}; DONE=1; go to DONE_ST.
- DONE_ST: hold Product and DONE; a START accept here restarts as from IDLE.
- START in RUN or FIX is ignored. It is neither queued nor does it restart the operation.
- Operands may change freely after the accepting edge.
- Range: the full signed range is exact and there is no overflow. A zero result is always 16'h0000, never negative zero, even when neg=1.

## Timing
- Reset (RESET_N=0 at an edge), from any state including mid-RUN:
  - state goes to IDLE.
  - Product=16'h0000, DONE=0, BUSY=0.
  - Internal registers are cleared; any in-progress result is discarded.
- Reset has priority over START at the same edge.
- Latency: START is accepted at edge 0. RUN covers edges 1–8 and FIX is edge 9. Product is valid and DONE=1 after edge 9, a fixed latency of 9 cycles.
- BUSY is 1 after edge 0 through edge 8 and drops after edge 9 (the same edge at which DONE rises).
- Back-to-back operation: START held high in DONE_ST is accepted at the next edge. DONE falls after that edge; Product keeps the old value until the new FIX edge.
- DONE is a level, not a pulse. The minimum DONE-high time is 1 cycle.

## Test plan
- Unsigned: 7 x 6, START pulse of one cycle -> BUSY for 9 cycles; after edge 9, Product=16'h002A, DONE=1, and both hold until the next START.
- Mixed signs: -7 (8'hF9) x 6 -> 16'hFFD6. Also 7 x -6 -> 16'hFFD6, and -7 x -6 -> 16'h002A.
- Extremes:
  - -128 x -128 -> 16'h4000.
  - -128 x 127 -> 16'hC080.
  - 127 x 127 -> 16'h3F01.
  - 0 x -5 -> 16'h0000.
- START ignored while busy: 3 x 4 started, then START pulsed at edge 4 with operands 9,9 -> result 16'h000C at edge 9, with no restart.
- Reset mid-operation: RESET_N=0 at edge 5 of 100 x 2 -> Product=0, DONE=0, BUSY=0. A new 2 x 3 then completes 9 cycles after its START with 16'h0006.
- Back-to-back: START held high continuously with 5 x 5, then operands changed to -1 x 1 after the first DONE. Required response:
  - 16'h0019 with DONE high for exactly 1 cycle.
  - Then 16'hFFFF 9 cycles after the second accept.
